i2c_slave_capture: RTL and testbench

- Parametrised, synthesisable I2C write-only slave.
- Oversamples i2c_sclk/i2c_sdat on the system clock, ACKs frames addressed to DEV_ADDR, and presents each complete payload as one parallel word with a single-cycle valid strobe.
- Successor to the fixed 3-byte codec-bus model: device address, payload length and sync depth are configurable; framing errors and NACK conditions are reported.
- Used as the codec-side endpoint in codec_top benches and as a control-port receiver in future multi-device configurations.

---
 rtl/i2c_slave_capture.sv | 172 +++++++++++++++++
 tb/tb_i2c_slave_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_capture.sv
// Write-only I2C slave: oversamples SCL/SDA, ACKs frames for DEV_ADDR, emits each payload as one word.
// Optional macro I2C_CAPTURE_REGFILE_EN (DATA_BYTES==2 only) adds a WM8731-style 128x9 register file.
module i2c_slave_capture #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         DATA_BYTES  = 2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i2c_sclk,
  inout  wire                     i2c_sdat,
  output logic [8*DATA_BYTES-1:0] pkt_data,
  output logic                    pkt_valid,
  output logic                    frame_err,
  output logic                    bus_busy
`ifdef I2C_CAPTURE_REGFILE_EN
  ,
  input  logic [6:0]              reg_rd_addr,
  output logic [8:0]              reg_rd_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  localparam logic [2:0] LP_BYTES = 3'(DATA_BYTES);

  logic [SYNC_STAGES-1:0]  r_scl_sync, r_sda_sync;
  logic                    r_scl_d, r_sda_d;
  state_t                  r_state, w_next;
  logic [2:0]              r_bit_cnt, r_byte_cnt;
  logic [7:0]              r_shift;
  logic                    r_full, r_part, r_extra, r_matched;
  logic [8*DATA_BYTES-1:0] r_payload;
  logic                    w_sda_oe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_sclk};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sdat};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_addr_ok, w_partial, w_in_prog, w_good;
  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_addr_ok  = (r_shift[7:1] == DEV_ADDR) && !r_shift[0];

  // A bit only counts once its clock pulse has fallen: the SCL rise that sets up
  // a STOP or repeated START is never mistaken for payload.
  assign w_partial = (r_state == S_DATA) && (r_part || r_full);
  assign w_in_prog = r_matched && ((r_byte_cnt != 3'd0) || w_partial || r_extra);
  assign w_good    = r_matched && (r_byte_cnt == LP_BYTES) && !r_extra && !w_partial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_stop) begin
      w_next = S_IDLE;
    end else if (w_start) begin
      w_next = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:     if (w_scl_fall && r_full) w_next = w_addr_ok ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (w_scl_fall) w_next = S_DATA;
        S_DATA:     if (w_scl_fall && r_full) w_next = S_DATA_ACK;
        S_DATA_ACK: if (w_scl_fall) w_next = (r_byte_cnt < LP_BYTES) ? S_DATA : S_IGNORE;
        default:    w_next = r_state;
      endcase
    end
  end

  // ACK drive comes straight from the state register so reset releases SDA at once.
  always_comb begin
    w_sda_oe = (r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK);
    bus_busy = (r_state != S_IDLE);
  end

  assign i2c_sdat = w_sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_full     <= 1'b0;
      r_part     <= 1'b0;
      r_extra    <= 1'b0;
      r_matched  <= 1'b0;
      r_payload  <= '0;
      pkt_data   <= '0;
      pkt_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      if (w_stop || w_start) begin
        if (w_stop && w_good) begin
          pkt_data  <= r_payload;
          pkt_valid <= 1'b1;
        end else if (r_state != S_IDLE && w_in_prog) begin
          frame_err <= 1'b1;
        end
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_full     <= 1'b0;
        r_part     <= 1'b0;
        r_extra    <= 1'b0;
        r_matched  <= 1'b0;
      end else if (w_scl_rise && (r_state == S_ADDR || r_state == S_DATA)) begin
        r_shift   <= {r_shift[6:0], w_sda};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_full <= 1'b1;
      end else if (w_scl_fall) begin
        case (r_state)
          S_ADDR: if (r_full) begin
            r_full    <= 1'b0;
            r_matched <= w_addr_ok;
          end
          S_DATA: if (r_full) begin
            for (int b = 0; b < DATA_BYTES; b++)
              if (r_byte_cnt == 3'(b)) r_payload[8*(DATA_BYTES-1-b) +: 8] <= r_shift;
            if (r_byte_cnt < LP_BYTES) r_byte_cnt <= r_byte_cnt + 3'd1;
            r_full <= 1'b0;
            r_part <= 1'b0;
          end else if (r_bit_cnt != 3'd0) begin
            r_part <= 1'b1;
          end
          S_IGNORE: if (r_matched) r_extra <= 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef I2C_CAPTURE_REGFILE_EN
  logic [8:0] r_regs [128];

  // Register 0x0F is the codec reset register: writing it wipes the file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) r_regs[i] <= '0;
    end else if (w_stop && w_good) begin
      if (r_payload[15:9] == 7'h0F) begin
        for (int i = 0; i < 128; i++) r_regs[i] <= '0;
      end else begin
        r_regs[r_payload[15:9]] <= r_payload[8:0];
      end
    end
  end

  assign reg_rd_data = r_regs[reg_rd_addr];
`endif

endmodule

// File: tb/tb_i2c_slave_capture.sv
// Self-checking bench for i2c_slave_capture: directed and random frames against a frame-level model.
module tb_i2c_slave_capture;
  localparam logic [6:0] DEV = 7'h1A;
  localparam int DB = 2;
  localparam int Q  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        m_low;
  wire         sda;
  logic [15:0] pkt_data;
  logic        pkt_valid, frame_err, bus_busy;
`ifdef I2C_CAPTURE_REGFILE_EN
  logic [6:0]  reg_rd_addr;
  logic [8:0]  reg_rd_data;
`endif

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_capture #(.DEV_ADDR(DEV), .DATA_BYTES(DB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i2c_sclk(scl), .i2c_sdat(sda),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .frame_err(frame_err), .bus_busy(bus_busy)
`ifdef I2C_CAPTURE_REGFILE_EN
    , .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_last = '0;
  logic [7:0]  fb [8];
  bit          in_bus = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expected payload.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_cnt++;
      if (pkt_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) check("unexpected_valid", pkt_data, 32'hFFFF_FFFF);
        else                   check("pkt_data", pkt_data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    if (scl) begin
      m_low = 1'b1; wait_q(); scl = 1'b0; wait_q();
    end else begin
      m_low = 1'b0; wait_q(); scl = 1'b1; wait_q();
      m_low = 1'b1; wait_q(); scl = 1'b0; wait_q();
    end
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q(); scl = 1'b1; wait_q();
    m_low = 1'b0; wait_q(); wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      m_low = !b[i]; wait_q();
      scl = 1'b1; wait_q(); wait_q();
      scl = 1'b0; wait_q();
    end
  endtask

  task automatic ack_slot(output bit acked);
    m_low = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    @(negedge clk) acked = (sda === 1'b0);
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  // Frame-level model: outcome depends only on address match, byte count and trailing bits.
  task automatic run_frame(input int nb, input int partial, input bit restart_end);
    int  v0, e0, n;
    bit  matched, exp_valid, exp_err, acked;
    v0 = valid_cnt; e0 = err_cnt;
    n = nb - 1;
    matched   = (fb[0] == {DEV, 1'b0});
    exp_valid = matched && !restart_end && (n == DB) && (partial == 0);
    exp_err   = matched && !exp_valid && ((n > 0) || (partial > 0));
    if (exp_valid) begin
      exp_q.push_back({fb[1], fb[2]});
      model_last = {fb[1], fb[2]};
    end
    if (!in_bus) i2c_start();
    in_bus = 1'b0;
    @(negedge clk) check("busy_after_start", bus_busy, 1'b1);
    for (int i = 0; i < nb; i++) begin
      send_bits(fb[i], 8);
      ack_slot(acked);
      check($sformatf("ack_byte%0d", i), acked, matched && (i <= DB));
    end
    if (partial > 0) send_bits(8'($urandom_range(0, 255)), partial);
    if (restart_end) begin
      i2c_start();
      in_bus = 1'b1;
      @(negedge clk) check("busy_after_rstart", bus_busy, 1'b1);
    end else begin
      i2c_stop();
      repeat (8) @(negedge clk);
      check("busy_after_stop", bus_busy, 1'b0);
    end
    check("valid_pulses", valid_cnt - v0, exp_valid);
    check("err_pulses", err_cnt - e0, exp_err);
    check("pkt_data_hold", pkt_data, model_last);
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    fb[0] = a; fb[1] = b; fb[2] = c;
  endtask

  initial begin
    bit acked;
    reset = 1'b1; scl = 1'b1; m_low = 1'b0;
`ifdef I2C_CAPTURE_REGFILE_EN
    reg_rd_addr = '0;
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_pkt_data", pkt_data, 16'h0);
    check("rst_pkt_valid", pkt_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_bus_busy", bus_busy, 1'b0);
    check("rst_sda", sda, 1'b1);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    set3(8'h34, 8'h1E, 8'h00); run_frame(3, 0, 1'b0);
    set3(8'h36, 8'hAA, 8'h55); run_frame(3, 0, 1'b0);
    set3(8'h34, 8'h12, 8'h00); run_frame(2, 0, 1'b0);
    set3(8'h35, 8'h00, 8'h00); run_frame(1, 0, 1'b0);
    set3(8'h34, 8'h00, 8'h00); run_frame(1, 0, 1'b0);
    fb[3] = 8'h77; set3(8'h34, 8'h01, 8'h02); run_frame(4, 0, 1'b0);
    set3(8'h34, 8'h0C, 8'h9F); run_frame(1, 5, 1'b1);
    run_frame(3, 0, 1'b0);

    // Reset while the slave is holding the address ACK.
    i2c_start();
    send_bits(8'h34, 8);
    m_low = 1'b0; wait_q();
    scl = 1'b1; repeat (2) @(posedge clk);
    @(negedge clk) check("ack_before_reset", sda, 1'b0);
    reset = 1'b1;
    #1;
    check("sda_released_async", sda, 1'b1);
    check("rst_mid_busy", bus_busy, 1'b0);
    check("rst_mid_pkt_data", pkt_data, 16'h0);
    model_last = '0;
    repeat (4) @(posedge clk);
    scl = 1'b1; m_low = 1'b0;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    set3(8'h34, 8'hAB, 8'hCD); run_frame(3, 0, 1'b0);

`ifdef I2C_CAPTURE_REGFILE_EN
    set3(8'h34, 8'h0E, 8'h4A); run_frame(3, 0, 1'b0);
    reg_rd_addr = 7'd7;
    @(negedge clk) check("reg7", reg_rd_data, 9'h04A);
    set3(8'h34, 8'h1E, 8'h00); run_frame(3, 0, 1'b0);
    for (int a = 0; a < 128; a += 7) begin
      reg_rd_addr = 7'(a);
      @(negedge clk) check("reg_cleared", reg_rd_data, 9'h000);
    end
`endif

    for (int k = 0; k < 30; k++) begin
      int sel, nb, part;
      sel = $urandom_range(0, 4);
      fb[0] = (sel < 2) ? 8'h34 : (sel == 2) ? 8'h35 : (sel == 3) ? 8'h36 : 8'($urandom_range(0, 255));
      for (int i = 1; i < 8; i++) fb[i] = 8'($urandom_range(0, 255));
      nb   = $urandom_range(1, DB + 2);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(nb, part, $urandom_range(0, 4) == 0);
    end
    if (in_bus) begin
      i2c_stop();
      repeat (8) @(negedge clk);
      in_bus = 1'b0;
    end
    check("final_idle", bus_busy, 1'b0);
    acked = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
